// File: rtl/param_serial_divider.sv
// ---------------------------------------------------------------------------
// param_serial_divider
//
// Radix-2 restoring serial divider with a configurable operand width and
// per-operation signed/unsigned mode. It produces one quotient bit per clock.
// Operands enter through a valid/ready handshake and results leave through
// another one. Divide-by-zero and signed MIN / -1 bypass the iteration and
// return fixed results, each flagged by its own status bit.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 4)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   in_valid     operands valid
//   in_ready     divider can accept operands (IDLE only)
//   is_signed    1 = two's-complement operation, 0 = unsigned
//   dividend     dividend
//   divisor      divisor
//   out_valid    result valid
//   out_ready    consumer accepts result
//   quotient     quotient, truncated toward zero
//   remainder    remainder, sign follows dividend
//   div_by_zero  result came from a zero divisor
//   overflow     result came from signed MIN / -1
//   busy         operation in progress (state != IDLE)
// ---------------------------------------------------------------------------
module param_serial_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + ONE_VAL;
    endfunction

    // Magnitude of a value: negative two's-complement inputs are negated
    // only in signed mode. MIN maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v,
                                               input logic             sgn);
        return (sgn && v[WIDTH-1]) ? f_neg(v) : v;
    endfunction

    // Control and operand registers
    state_t           r_state;
    logic             r_signed;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_abs_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [CNT_W-1:0] r_cnt;

    // Working/result registers. During CALC r_quo starts as the dividend
    // magnitude and is shifted out MSB-first while quotient bits enter at
    // the LSB. r_rem holds the partial remainder between iterations.
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_out_valid;
    logic             r_dz;
    logic             r_ov;

    // PREP-stage decodes of the latched operands
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic w_zero_div;
    logic w_ovf;

    assign w_dvd_neg  = r_signed & r_dvd[WIDTH-1];
    assign w_dvs_neg  = r_signed & r_dvs[WIDTH-1];
    assign w_zero_div = (r_dvs == '0);
    assign w_ovf      = r_signed && (r_dvd == MIN_VAL) && (r_dvs == '1);

    // CALC-stage trial subtraction. The shifted partial remainder needs
    // WIDTH+1 bits because it can reach 2*divisor-1. When the trial fits,
    // the difference is below the divisor, so its low WIDTH bits are exact.
    logic [WIDTH:0]   w_part_rem;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    assign w_part_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_fits     = (w_part_rem >= {1'b0, r_abs_dvs});
    assign w_diff     = w_part_rem[WIDTH-1:0] - r_abs_dvs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
        end else begin
            unique case (r_state)
                // Accept a new operation
                S_IDLE: begin
                    if (in_valid) begin
                        r_signed <= is_signed;
                        r_dvd    <= dividend;
                        r_dvs    <= divisor;
                        r_state  <= S_PREP;
                    end
                end

                // Resolve special cases or set up the iteration
                S_PREP: begin
                    r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                    r_r_neg   <= w_dvd_neg;
                    r_abs_dvs <= f_abs(r_dvs, r_signed);
                    if (w_zero_div) begin
                        r_quo       <= '1;
                        r_rem       <= r_dvd;
                        r_dz        <= 1'b1;
                        r_ov        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_ovf) begin
                        r_quo       <= MIN_VAL;
                        r_rem       <= '0;
                        r_dz        <= 1'b0;
                        r_ov        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_quo   <= f_abs(r_dvd, r_signed);
                        r_rem   <= '0;
                        r_dz    <= 1'b0;
                        r_ov    <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_CALC;
                    end
                end

                // One quotient bit per cycle
                S_CALC: begin
                    r_rem <= w_fits ? w_diff : w_part_rem[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end

                // Apply result signs; the neg flags are only set in signed mode
                S_FIX: begin
                    if (r_q_neg) begin
                        r_quo <= f_neg(r_quo);
                    end
                    if (r_r_neg) begin
                        r_rem <= f_neg(r_rem);
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                // Hold the result until the consumer takes it
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule
